lzc_pipe: RTL
=============

// Module: lzc_pipe
// PURPOSE
//  Pipelined, parametrised leading/trailing-zero counter with valid/ready streaming handshake.
//  Generalises the fixed 8/32-bit combinational counters: any power-of-2 WIDTH, configurable register spacing, per-beat mode, tag passthrough.
//  Sits in buffet datapaths (sparse-index/bitmask scan) where a full-width count in one cycle misses timing.
// PARAMETERS
//  WIDTH      32  data width; power of 2, 2..256
//  REG_EVERY  2   tree levels between pipeline registers; >=1
//  TAG_W      4   width of opaque sideband tag carried with each beat; >=1
// PORTS
//  clk        in   1              clock, rising edge
//  reset      in   1              asynchronous, active-high
//  in_valid   in   1              input beat valid
//  in_ready   out  1              block can accept a beat
//  in_data    in   WIDTH          vector to scan
//  in_mode    in   1              0 = count leading zeros (from MSB), 1 = trailing zeros (from LSB)
//  in_tag     in   TAG_W          sideband, returned unchanged
//  out_valid  out  1              result valid
//  out_ready  in   1              consumer accepts result
//  out_count  out  CW             zero count, CW = $clog2(WIDTH)+1
//  out_zero   out  1              in_data was all zeros
//  out_tag    out  TAG_W          tag of this beat
// BEHAVIOUR
//  - One clock, clk. Reset asynchronous, active-high: all stage valids, out_valid, out_count, out_zero, out_tag -> 0. in_ready = 1 in the first cycle after reset deasserts.
//  - Transfer on in_valid & in_ready (input) and out_valid & out_ready (output).
//  - Tree: LEVELS = log2(WIDTH). Level 0 encodes 2-bit pairs (00->2, 01->1, 1x->0); level k merges pairs of (k+1)-bit counts into (k+2)-bit counts:
//    left saturated & right saturated -> {1,0..}; left saturated only -> {01, right[low]}; else {0, left}.
//  - Trailing mode bit-reverses in_data before level 0; rest of tree unchanged.
//  - out_count = number of zeros before the first 1 in scan direction; all-zero -> WIDTH with out_zero = 1; out_zero = 0 otherwise.
//  - Pipeline: register after every REG_EVERY levels; last level always registered.
//    NSTAGES = ceil(LEVELS/REG_EVERY); latency accept -> out_valid = NSTAGES cycles with no back-pressure. WIDTH=32, REG_EVERY=2: 3.
//  - Each stage holds valid, partial counts, mode-independent data, tag. Stage s advances when stage s+1 is empty or advancing; last stage advances on out_ready.
//  - in_ready = ~v[0] | adv[0] (combinational from out_ready through the valid chain; no bubble). Throughput 1 beat/cycle when out_ready held 1.
//  - Stall: out_valid & ~out_ready -> out_count/out_zero/out_tag held stable; no beat dropped or duplicated; order preserved.
//  - Full pipe + out_ready=0 -> in_ready=0; in_valid ignored. Simultaneous accept and emit on a full pipe allowed.
//  - Data registers load only on stage advance (no enable on reset path). Reset mid-operation flushes all beats; no output for them.
//  - in_mode sampled with the beat; modes may alternate every cycle.
// STRUCTURE
//  - Package lzc_pkg: function lzc_clog2, localparam helpers for CW/LEVELS/NSTAGES, mode encoding constants LZC_LEAD=0, LZC_TRAIL=1.
//  - Sub-module lzc_merge #(W): one tree level node, combinational, W-bit counts in -> W+1 out; instantiated in generate loops.
//  - lzc_pipe owns the encode level, generate-built levels, stage registers and handshake.
// TESTING
//  1. WIDTH=32, lead, 0x80000000 / 0x00000001 / 0x00000008 / 0x00000003 -> count 0 / 31 / 28 / 30, out_zero=0.
//  2. in_data=0 in both modes -> count 32, out_zero=1. Trail, 0x80000000 -> 31; 0x00000008 -> 3.
//  3. Stream 16 beats, tags 0..15, out_ready=1 -> out_valid 3 cycles after first accept, 1 result/cycle, tags in order.
//  4. out_ready=0 for 6 cycles mid-stream -> in_ready drops after 3 beats are buffered; output held stable; no loss on release.
//  5. Assert reset with 2 beats in flight -> out_valid=0 asynchronously; next beat after release returns correct count with latency 3.
//  6. Sweep WIDTH in {2,8,64}, REG_EVERY in {1,2,LEVELS}: random data vs behavioural model, both modes; latency = NSTAGES.

Source files
------------

// File: rtl/lzc_pkg.sv
// lzc_pkg: shared sizing helpers and scan-mode encoding for the zero counter
package lzc_pkg;
    typedef enum logic {
        LZC_LEAD  = 1'b0,
        LZC_TRAIL = 1'b1
    } lzc_mode_e;

    function automatic int lzc_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int lzc_levels(input int width);
        return lzc_clog2(width);
    endfunction

    function automatic int lzc_cw(input int width);
        return lzc_clog2(width) + 1;
    endfunction

    function automatic int lzc_nstages(input int width, input int reg_every);
        return (lzc_clog2(width) + reg_every - 1) / reg_every;
    endfunction
endpackage

// File: rtl/lzc_merge.sv
// lzc_merge: combine the zero counts of two adjacent halves into one count a bit wider
module lzc_merge
    import lzc_pkg::*;
#(
    parameter int W = 2
) (
    input  logic [W-1:0] left,
    input  logic [W-1:0] right,
    output logic [W:0]   cnt
);
    assign cnt = (left[W-1] & right[W-1]) ? {1'b1, {W{1'b0}}}
               : left[W-1]                ? {2'b01, right[W-2:0]}
               :                            {1'b0, left};
endmodule

// File: rtl/lzc_pipe.sv
// lzc_pipe: pipelined leading/trailing-zero counter with valid/ready streaming handshake
module lzc_pipe
    import lzc_pkg::*;
#(
    parameter  int WIDTH     = 32,
    parameter  int REG_EVERY = 2,
    parameter  int TAG_W     = 4,
    localparam int CW        = lzc_cw(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_count,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);
    localparam int LEVELS = lzc_levels(WIDTH);
    localparam int NST    = lzc_nstages(WIDTH, REG_EVERY);

    logic [WIDTH-1:0]          rev, din;
    logic [NST-1:0]            v, adv, ld;
    logic [NST-1:0][TAG_W-1:0] tg, tin;

    assign rev = {<<{in_data}};
    assign din = (in_mode == LZC_TRAIL) ? rev : in_data;

    // a stage moves on when some later stage is empty or the consumer takes the head
    for (genvar s = 0; s < NST; s++) begin : g_adv
        if (s == NST - 1) begin : g_last
            assign adv[s] = v[s] & out_ready;
        end else begin : g_mid
            assign adv[s] = v[s] & (out_ready | ~(&v[NST-1:s+1]));
        end
    end

    assign in_ready  = ~v[0] | adv[0];
    assign out_valid = v[NST-1];
    assign out_tag   = tg[NST-1];
    assign out_count = lv[LEVELS-1].g_q.q;
    assign out_zero  = out_count[CW-1];

    // each stage loads whatever its upstream neighbour (or the input port) hands over
    always_comb begin
        ld     = '0;
        tin    = '0;
        ld[0]  = in_valid & in_ready;
        tin[0] = in_tag;
        for (int s = 1; s < NST; s++) begin
            ld[s]  = adv[s-1];
            tin[s] = tg[s-1];
        end
    end

    // stage valids and tags; a stage stays full unless it advances without a refill
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v  <= '0;
            tg <= '0;
        end else begin
            for (int s = 0; s < NST; s++) begin
                v[s] <= ld[s] | (v[s] & ~adv[s]);
                if (ld[s]) tg[s] <= tin[s];
            end
        end
    end

    for (genvar k = 0; k < LEVELS; k++) begin : lv
        localparam int N = WIDTH >> (k + 1);
        logic [N*(k+2)-1:0] c;
        if (k == 0) begin : g_enc
            for (genvar j = 0; j < N; j++) begin : g_n
                assign c[2*j +: 2] = din[WIDTH-1-2*j] ? 2'd0 : din[WIDTH-2-2*j] ? 2'd1 : 2'd2;
            end
        end else begin : g_mrg
            logic [2*N*(k+1)-1:0] a;
            if (k % REG_EVERY == 0) begin : g_r
                assign a = lv[k-1].g_q.q;
            end else begin : g_c
                assign a = lv[k-1].c;
            end
            for (genvar j = 0; j < N; j++) begin : g_n
                lzc_merge #(.W(k + 1)) u_merge (
                    .left (a[(2*j)*(k+1) +: k+1]),
                    .right(a[(2*j+1)*(k+1) +: k+1]),
                    .cnt  (c[j*(k+2) +: k+2])
                );
            end
        end
        if ((k + 1) % REG_EVERY == 0 || k == LEVELS - 1) begin : g_q
            logic [N*(k+2)-1:0] q;
            // partial counts follow their beat down the pipe
            always_ff @(posedge clk or posedge reset) begin
                if (reset) q <= '0;
                else if (ld[k / REG_EVERY]) q <= c;
            end
        end
    end
endmodule
